// File: rtl/mem_rr_arbiter_if.sv
// Requester-side and controller-side signal bundle for mem_rr_arbiter.
// Upstream fields are packed per port; port p occupies slice p of each vector.
interface mem_rr_arbiter_if #(
    parameter int PORT_COUNT      = 4,
    parameter int DATA_WIDTH_BYTE = 4,
    parameter int ADDR_WIDTH_BYTE = 4
);
    localparam int DW = 8 * DATA_WIDTH_BYTE;
    localparam int AW = 8 * ADDR_WIDTH_BYTE;

    logic [PORT_COUNT*2-1:0]               rw_flag;
    logic [PORT_COUNT*AW-1:0]              addr;
    logic [PORT_COUNT*DW-1:0]              write_data;
    logic [PORT_COUNT*DATA_WIDTH_BYTE-1:0] write_mask;
    logic [PORT_COUNT*DW-1:0]              read_data;
    logic [PORT_COUNT-1:0]                 busy;
    logic [PORT_COUNT-1:0]                 done;
    logic [PORT_COUNT-1:0]                 err;

    logic [1:0]                            m_rw_flag;
    logic [AW-1:0]                         m_addr;
    logic [DW-1:0]                         m_write_data;
    logic [DATA_WIDTH_BYTE-1:0]            m_write_mask;
    logic [DW-1:0]                         m_read_data;
    logic                                  m_busy;
    logic                                  m_done;

    // The arbiter itself.
    modport slave (
        input  rw_flag, addr, write_data, write_mask,
        input  m_read_data, m_busy, m_done,
        output read_data, busy, done, err,
        output m_rw_flag, m_addr, m_write_data, m_write_mask
    );

    // The surrounding environment: requesters plus the memory controller.
    modport master (
        output rw_flag, addr, write_data, write_mask,
        output m_read_data, m_busy, m_done,
        input  read_data, busy, done, err,
        input  m_rw_flag, m_addr, m_write_data, m_write_mask
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one memory controller port between PORT_COUNT requesters,
// with a one-deep pending slot per port and a per-transaction watchdog.
module mem_rr_arbiter #(
    parameter int PORT_COUNT      = 4,
    parameter int DATA_WIDTH_BYTE = 4,
    parameter int ADDR_WIDTH_BYTE = 4,
    parameter int TIMEOUT         = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_rr_arbiter_if.slave   bus
);
    localparam int DW     = 8 * DATA_WIDTH_BYTE;
    localparam int AW     = 8 * ADDR_WIDTH_BYTE;
    localparam int MW     = DATA_WIDTH_BYTE;
    localparam int GW     = (PORT_COUNT > 1) ? $clog2(PORT_COUNT) : 1;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_M1  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST   = TO_M1[CNT_W-1:0];
    localparam logic [GW-1:0]    LAST_INIT = GW'(PORT_COUNT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t                   state;
    logic [GW-1:0]            grant;
    logic [GW-1:0]            last_grant;
    logic [CNT_W-1:0]         cnt;

    logic [PORT_COUNT-1:0]    slot_vld;
    logic [1:0]               slot_flag [PORT_COUNT];
    logic [AW-1:0]            slot_addr [PORT_COUNT];
    logic [DW-1:0]            slot_data [PORT_COUNT];
    logic [MW-1:0]            slot_mask [PORT_COUNT];

    logic [PORT_COUNT*DW-1:0] read_data_q;
    logic [PORT_COUNT-1:0]    done_q;
    logic [PORT_COUNT-1:0]    err_q;

    logic [AW-1:0]            hold_addr;
    logic [DW-1:0]            hold_data;
    logic [MW-1:0]            hold_mask;

    logic [GW:0]              nxt;
    logic                     issue;
    logic                     timeout_hit;

    function automatic logic is_req(input logic [1:0] flag);
        return (flag == 2'd1) || (flag == 2'd2);
    endfunction

    // First valid slot after last_grant, wrapping; MSB of the result flags a hit.
    function automatic logic [GW:0] pick_next(input logic [PORT_COUNT-1:0] vld,
                                              input logic [GW-1:0]         last);
        logic [GW:0] res;
        int          idx;
        res = '0;
        for (int i = PORT_COUNT; i >= 1; i--) begin
            idx = (int'(last) + i) % PORT_COUNT;
            if (vld[idx]) begin
                res = {1'b1, GW'(idx)};
            end
        end
        return res;
    endfunction

    assign nxt         = pick_next(slot_vld, last_grant);
    assign issue       = (state == ST_ISSUE) && !bus.m_busy;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);

    // The request is presented only in the cycle the controller accepts it; the
    // address/data/mask lines otherwise keep showing the last issued request.
    assign bus.m_rw_flag    = issue ? slot_flag[grant] : 2'd0;
    assign bus.m_addr       = issue ? slot_addr[grant] : hold_addr;
    assign bus.m_write_data = issue ? slot_data[grant] : hold_data;
    assign bus.m_write_mask = issue ? slot_mask[grant] : hold_mask;

    assign bus.busy      = slot_vld;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.read_data = read_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant       <= '0;
            last_grant  <= LAST_INIT;
            cnt         <= '0;
            slot_vld    <= '0;
            done_q      <= '0;
            err_q       <= '0;
            read_data_q <= '0;
            hold_addr   <= '0;
            hold_data   <= '0;
            hold_mask   <= '0;
            for (int p = 0; p < PORT_COUNT; p++) begin
                slot_flag[p] <= '0;
                slot_addr[p] <= '0;
                slot_data[p] <= '0;
                slot_mask[p] <= '0;
            end
        end else begin
            done_q <= '0;
            err_q  <= '0;

            // Capture into free slots; an occupied slot ignores its port entirely.
            for (int p = 0; p < PORT_COUNT; p++) begin
                if (!slot_vld[p] && is_req(bus.rw_flag[2*p +: 2])) begin
                    slot_vld[p]  <= 1'b1;
                    slot_flag[p] <= bus.rw_flag[2*p +: 2];
                    slot_addr[p] <= bus.addr[AW*p +: AW];
                    slot_data[p] <= bus.write_data[DW*p +: DW];
                    slot_mask[p] <= bus.write_mask[MW*p +: MW];
                end
            end

            unique case (state)
                ST_IDLE: begin
                    if (nxt[GW]) begin
                        grant <= nxt[GW-1:0];
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (!bus.m_busy) begin
                        hold_addr <= slot_addr[grant];
                        hold_data <= slot_data[grant];
                        hold_mask <= slot_mask[grant];
                        cnt       <= '0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A real completion wins over a watchdog expiry on the same cycle.
                    if (bus.m_done || timeout_hit) begin
                        slot_vld[grant] <= 1'b0;
                        done_q[grant]   <= 1'b1;
                        err_q[grant]    <= !bus.m_done;
                        last_grant      <= grant;
                        state           <= ST_IDLE;
                        if (!bus.m_done) begin
                            read_data_q[int'(grant)*DW +: DW] <= '0;
                        end else if (slot_flag[grant] == 2'd1) begin
                            read_data_q[int'(grant)*DW +: DW] <= bus.m_read_data;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
